// File: rtl/bc6502_pkg.sv
// Shared constants and FSM encoding for the bc6502 ADC/SBC datapath.
package bc6502_pkg;

    localparam logic OP_ADC = 1'b0;
    localparam logic OP_SBC = 1'b1;

    localparam logic [3:0] BCD_ADJ = 4'd6;
    localparam logic [3:0] BCD_MAX = 4'd9;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CALC  = 2'd1,
        ST_DADJ  = 2'd2,
        ST_DADJ2 = 2'd3
    } state_t;

endpackage

// File: rtl/bc6502_bcd_nib_adj.sv
// BCD nibble adjust: add mode folds in the carry and applies the +6 fix,
// subtract mode removes 6 when the nibble borrowed.
module bc6502_bcd_nib_adj
    import bc6502_pkg::*;
(
    input  logic [4:0] i_nib,
    input  logic       i_carry,
    input  logic       i_sub,
    output logic [3:0] o_nib,
    output logic       o_carry
);

    logic [5:0] w_sum;
    logic [5:0] w_fix;

    always_comb begin
        w_sum   = {1'b0, i_nib} + {5'b0, i_carry};
        w_fix   = (w_sum > {2'b00, BCD_MAX}) ? w_sum + {2'b00, BCD_ADJ} : w_sum;
        o_nib   = w_fix[3:0];
        o_carry = (w_fix > 6'd15);
        if (i_sub) begin
            o_nib   = i_carry ? i_nib[3:0] - BCD_ADJ : i_nib[3:0];
            o_carry = i_carry;
        end
    end

endmodule

// File: rtl/bc6502_addsub_unit.sv
// Registered ADC/SBC unit with start/busy/done handshake and BCD adjust.
// Define BC6502_CMOS_DECIMAL_EN for 65C02 decimal flags (extra DADJ2 cycle).
module bc6502_addsub_unit
    import bc6502_pkg::*;
#(
    parameter int WID = 8
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic           op,
    input  logic           dec,
    input  logic [WID-1:0] a,
    input  logic [WID-1:0] b,
    input  logic           ci,
    output logic           busy,
    output logic           done,
    output logic [WID-1:0] res,
    output logic           co,
    output logic           v,
    output logic           n,
    output logic           z
);

    state_t         r_state;
    state_t         w_state_nx;
    logic [WID-1:0] r_a;
    logic [WID-1:0] r_b;
    logic           r_ci;
    logic           r_op;
    logic           r_dec;
    logic           r_done;
    logic [WID-1:0] r_res;
    logic           r_co;
    logic           r_v;
    logic           r_n;
    logic           r_z;

    logic           w_ld;
    logic           w_done_nx;
    logic [WID-1:0] w_res_nx;
    logic           w_co_nx;
    logic           w_v_nx;
    logic           w_n_nx;
    logic           w_z_nx;

    logic           w_sub;
    logic [WID-1:0] w_bb;
    logic [WID:0]   w_t;
    logic           w_bin_v;

    assign w_sub   = (r_op != OP_ADC);
    assign w_bb    = (r_op == OP_SBC) ? ~r_b : r_b;
    assign w_t     = {1'b0, r_a} + {1'b0, w_bb} + {{WID{1'b0}}, r_ci};
    assign w_bin_v = (r_a[WID-1] == w_bb[WID-1]) & (w_t[WID-1] != r_a[WID-1]);

    logic       w_lo_borrow;
    logic [4:0] w_lo_in;
    logic       w_lo_cin;
    logic [3:0] w_lo_adj;
    logic       w_lo_c;
    logic [4:0] w_hi_sum;
    logic [4:0] w_hi_pre;
    logic       w_hi_n;
    logic [4:0] w_hi_in;
    logic       w_hi_cin;
    logic [3:0] w_hi_adj;
    logic       w_hi_c;
    logic [7:0] w_dec_res;
    logic       w_dec_co;
    logic       w_dec_v;
    logic       w_dec_n;
    logic       w_dec_z;

    assign w_lo_borrow = {1'b0, r_a[3:0]} < ({1'b0, r_b[3:0]} + {4'b0, ~r_ci});
    assign w_lo_in     = w_sub ? {1'b0, w_t[3:0]} : {1'b0, r_a[3:0]} + {1'b0, r_b[3:0]};
    assign w_lo_cin    = w_sub ? w_lo_borrow : r_ci;

    bc6502_bcd_nib_adj u_lo (
        .i_nib   (w_lo_in),
        .i_carry (w_lo_cin),
        .i_sub   (w_sub),
        .o_nib   (w_lo_adj),
        .o_carry (w_lo_c)
    );

    // NMOS takes N and V from the high nibble before its +6 fix
    assign w_hi_sum = {1'b0, r_a[7:4]} + {1'b0, r_b[7:4]};
    assign w_hi_pre = w_hi_sum + {4'b0, w_lo_c};
    assign w_hi_n   = |(w_hi_pre & 5'b01000);
    assign w_hi_in  = w_sub ? {1'b0, w_t[7:4]} : w_hi_sum;
    assign w_hi_cin = w_sub ? ~w_t[WID] : w_lo_c;

    bc6502_bcd_nib_adj u_hi (
        .i_nib   (w_hi_in),
        .i_carry (w_hi_cin),
        .i_sub   (w_sub),
        .o_nib   (w_hi_adj),
        .o_carry (w_hi_c)
    );

    assign w_dec_res = {w_hi_adj, w_lo_adj};
    assign w_dec_co  = w_sub ? w_t[WID] : w_hi_c;
    assign w_dec_n   = w_sub ? w_t[7] : w_hi_n;
    assign w_dec_v   = w_sub ? w_bin_v : (r_a[7] == r_b[7]) & (w_hi_n != r_a[7]);
    assign w_dec_z   = (w_t[7:0] == 8'h00);

    always_comb begin
        w_state_nx = r_state;
        w_ld       = 1'b0;
        w_done_nx  = 1'b0;
        w_res_nx   = r_res;
        w_co_nx    = r_co;
        w_v_nx     = r_v;
        w_n_nx     = r_n;
        w_z_nx     = r_z;
        unique case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_ld       = 1'b1;
                    w_state_nx = ST_CALC;
                end
            end
            ST_CALC: begin
                if (r_dec) begin
                    w_state_nx = ST_DADJ;
                end else begin
                    w_res_nx   = w_t[WID-1:0];
                    w_co_nx    = w_t[WID];
                    w_v_nx     = w_bin_v;
                    w_n_nx     = w_t[WID-1];
                    w_z_nx     = (w_t[WID-1:0] == '0);
                    w_done_nx  = 1'b1;
                    w_state_nx = ST_IDLE;
                end
            end
            ST_DADJ: begin
`ifdef BC6502_CMOS_DECIMAL_EN
                w_state_nx = ST_DADJ2;
`else
                w_res_nx   = WID'(w_dec_res);
                w_co_nx    = w_dec_co;
                w_v_nx     = w_dec_v;
                w_n_nx     = w_dec_n;
                w_z_nx     = w_dec_z;
                w_done_nx  = 1'b1;
                w_state_nx = ST_IDLE;
`endif
            end
            ST_DADJ2: begin
`ifdef BC6502_CMOS_DECIMAL_EN
                w_res_nx   = WID'(w_dec_res);
                w_co_nx    = w_dec_co;
                w_v_nx     = w_dec_v;
                w_n_nx     = w_dec_res[7];
                w_z_nx     = (w_dec_res == 8'h00);
                w_done_nx  = 1'b1;
`endif
                w_state_nx = ST_IDLE;
            end
            default: w_state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_ci    <= 1'b0;
            r_op    <= 1'b0;
            r_dec   <= 1'b0;
            r_done  <= 1'b0;
            r_res   <= '0;
            r_co    <= 1'b0;
            r_v     <= 1'b0;
            r_n     <= 1'b0;
            r_z     <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_done  <= w_done_nx;
            r_res   <= w_res_nx;
            r_co    <= w_co_nx;
            r_v     <= w_v_nx;
            r_n     <= w_n_nx;
            r_z     <= w_z_nx;
            if (w_ld) begin
                r_a   <= a;
                r_b   <= b;
                r_ci  <= ci;
                r_op  <= op;
                r_dec <= dec;
            end
        end
    end

    assign busy = (r_state != ST_IDLE);
    assign done = r_done;
    assign res  = r_res;
    assign co   = r_co;
    assign v    = r_v;
    assign n    = r_n;
    assign z    = r_z;

endmodule

// File: tb/tb_bc6502_addsub_unit.sv
// Bench for bc6502_addsub_unit: vector table, random ops, handshake and reset cases.
module tb_bc6502_addsub_unit;

`ifdef BC6502_CMOS_DECIMAL_EN
    localparam int DEC_LAT = 3;
    localparam bit CMOS    = 1'b1;
`else
    localparam int DEC_LAT = 2;
    localparam bit CMOS    = 1'b0;
`endif
    localparam int NV = 13;

    typedef struct packed {
        logic [7:0] res;
        logic       co;
        logic       v;
        logic       n;
        logic       z;
    } exp_t;

    typedef struct {
        logic       op;
        logic       dec;
        logic [7:0] a;
        logic [7:0] b;
        logic       ci;
        exp_t       e;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       op;
    logic       dec;
    logic [7:0] a;
    logic [7:0] b;
    logic       ci;
    logic       busy;
    logic       done;
    logic [7:0] res;
    logic       co;
    logic       v;
    logic       n;
    logic       z;

    int   n_cmp  = 0;
    int   n_bad  = 0;
    int   n_done = 0;
    exp_t sbq[$];
    exp_t mon_e;
    vec_t vt[NV];

    always #5 clk = ~clk;

    bc6502_addsub_unit #(.WID(8)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .dec   (dec),
        .a     (a),
        .b     (b),
        .ci    (ci),
        .busy  (busy),
        .done  (done),
        .res   (res),
        .co    (co),
        .v     (v),
        .n     (n),
        .z     (z)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic exp_t model(input logic o, input logic d, input logic [7:0] x,
                                   input logic [7:0] y, input logic c);
        logic [8:0] t;
        logic [7:0] bb;
        int         lo;
        int         hi;
        exp_t       e;
        bb    = o ? ~y : y;
        t     = {1'b0, x} + {1'b0, bb} + {8'b0, c};
        e.res = t[7:0];
        e.co  = t[8];
        e.v   = (x[7] == bb[7]) && (t[7] != x[7]);
        e.n   = t[7];
        e.z   = (t[7:0] == 8'h00);
        if (d && !o) begin
            lo = int'(x[3:0]) + int'(y[3:0]) + int'(c);
            if (lo > 9) lo += 6;
            hi = int'(x[7:4]) + int'(y[7:4]) + ((lo > 15) ? 1 : 0);
            e.n = hi[3];
            e.v = (x[7] == y[7]) && (hi[3] != x[7]);
            if (hi > 9) hi += 6;
            e.co  = (hi > 15);
            e.res = {hi[3:0], lo[3:0]};
        end else if (d && o) begin
            lo = int'(t[3:0]);
            if (int'(x[3:0]) < int'(y[3:0]) + (c ? 0 : 1)) lo -= 6;
            hi = int'(t[7:4]);
            if (!t[8]) hi -= 6;
            e.res = {hi[3:0], lo[3:0]};
        end
        if (d && CMOS) begin
            e.n = e.res[7];
            e.z = (e.res == 8'h00);
        end
        return e;
    endfunction

    function automatic vec_t mk(input logic o, input logic d, input logic [7:0] x,
                                input logic [7:0] y, input logic c, input logic [7:0] r,
                                input logic fc, input logic fv, input logic fn, input logic fz);
        vec_t t;
        t.op  = o;
        t.dec = d;
        t.a   = x;
        t.b   = y;
        t.ci  = c;
        t.e   = '{res: r, co: fc, v: fv, n: fn, z: fz};
        return t;
    endfunction

    always @(negedge clk) begin
        if (done) begin
            n_done++;
            if (sbq.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_done: got done=1, expected no pending op");
            end else begin
                mon_e = sbq.pop_front();
                check("res", {24'b0, res}, {24'b0, mon_e.res});
                check("co", {31'b0, co}, {31'b0, mon_e.co});
                check("v", {31'b0, v}, {31'b0, mon_e.v});
                check("n", {31'b0, n}, {31'b0, mon_e.n});
                check("z", {31'b0, z}, {31'b0, mon_e.z});
            end
        end
    end

    // Called at a negedge; returns at the negedge where done was seen.
    task automatic run(input logic o, input logic d, input logic [7:0] x,
                       input logic [7:0] y, input logic c, input exp_t e, input string nm);
        int cnt;
        int lat;
        lat   = d ? DEC_LAT : 1;
        op    = o;
        dec   = d;
        a     = x;
        b     = y;
        ci    = c;
        start = 1'b1;
        sbq.push_back(e);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check({nm, "_busy"}, {31'b0, busy}, 32'd1);
        cnt = 0;
        while (!done && cnt < 8) begin
            @(negedge clk);
            cnt++;
        end
        check({nm, "_lat"}, cnt, lat);
        if (!done) sbq.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int cnt;
        int d0;
        logic       ro;
        logic       rd;
        logic       rc;
        logic [7:0] rx;
        logic [7:0] ry;

        reset = 1'b1;
        start = 1'b0;
        op    = 1'b0;
        dec   = 1'b0;
        a     = 8'h00;
        b     = 8'h00;
        ci    = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_res", {24'b0, res}, 32'd0);
        check("rst_flags", {28'b0, co, v, n, z}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        vt[0]  = mk(0, 0, 8'h50, 8'h50, 0, 8'hA0, 0, 1, 1, 0);
        vt[1]  = mk(1, 0, 8'h50, 8'hB0, 1, 8'hA0, 0, 1, 1, 0);
        vt[2]  = mk(0, 1, 8'h09, 8'h01, 0, 8'h10, 0, 0, 0, 0);
        vt[3]  = mk(0, 1, 8'h99, 8'h01, 0, 8'h00, 1, 0, !CMOS, CMOS);
        vt[4]  = mk(1, 1, 8'h10, 8'h01, 1, 8'h09, 1, 0, 0, 0);
        vt[5]  = mk(0, 0, 8'hFF, 8'h01, 0, 8'h00, 1, 0, 0, 1);
        vt[6]  = mk(1, 0, 8'h00, 8'h01, 1, 8'hFF, 0, 0, 1, 0);
        vt[7]  = mk(0, 0, 8'h7F, 8'h00, 1, 8'h80, 0, 1, 1, 0);
        vt[8]  = mk(1, 1, 8'h00, 8'h01, 1, 8'h99, 0, 0, 1, 0);
        vt[9]  = mk(0, 1, 8'h45, 8'h55, 1, 8'h01, 1, 1, !CMOS, 0);
        vt[10] = mk(1, 1, 8'h46, 8'h12, 1, 8'h34, 1, 0, 0, 0);
        vt[11] = mk(1, 1, 8'h40, 8'h13, 0, 8'h26, 1, 0, 0, 0);
        vt[12] = mk(0, 1, 8'h50, 8'h50, 0, 8'h00, 1, 1, !CMOS, CMOS);

        for (int i = 0; i < NV; i++) begin
            run(vt[i].op, vt[i].dec, vt[i].a, vt[i].b, vt[i].ci, vt[i].e, $sformatf("vec%0d", i));
            @(negedge clk);
            check("done_pulse", {31'b0, done}, 32'd0);
        end

        // back-to-back: each new start is raised in the done cycle
        for (int i = 0; i < 40; i++) begin
            ro = 1'($urandom_range(0, 1));
            rd = 1'($urandom_range(0, 1));
            rc = 1'($urandom_range(0, 1));
            if (rd) begin
                rx = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
                ry = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
            end else begin
                rx = 8'($urandom);
                ry = 8'($urandom);
            end
            run(ro, rd, rx, ry, rc, model(ro, rd, rx, ry, rc), "rnd");
        end
        @(negedge clk);

        run(vt[0].op, vt[0].dec, vt[0].a, vt[0].b, vt[0].ci, vt[0].e, "b2b_a");
        run(vt[4].op, vt[4].dec, vt[4].a, vt[4].b, vt[4].ci, vt[4].e, "b2b_b");
        @(negedge clk);

        // start held high through busy
        d0    = n_done;
        op    = 1'b0;
        dec   = 1'b1;
        a     = 8'h09;
        b     = 8'h01;
        ci    = 1'b0;
        start = 1'b1;
        sbq.push_back(vt[2].e);
        @(posedge clk);
        @(negedge clk);
        cnt = 0;
        while (!done && cnt < 8) begin
            @(negedge clk);
            cnt++;
        end
        start = 1'b0;
        check("held_lat", cnt, DEC_LAT);
        repeat (5) @(negedge clk);
        check("held_single", n_done - d0, 1);

        // reset while in CALC
        d0    = n_done;
        op    = 1'b0;
        dec   = 1'b1;
        a     = 8'h45;
        b     = 8'h55;
        ci    = 1'b1;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        check("rcalc_busy", {31'b0, busy}, 32'd0);
        check("rcalc_done", {31'b0, done}, 32'd0);
        check("rcalc_res", {24'b0, res}, 32'd0);
        check("rcalc_flags", {28'b0, co, v, n, z}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        run(vt[0].op, vt[0].dec, vt[0].a, vt[0].b, vt[0].ci, vt[0].e, "after_rcalc");
        @(negedge clk);

        // reset while in DADJ
        op    = 1'b1;
        dec   = 1'b1;
        a     = 8'h10;
        b     = 8'h01;
        ci    = 1'b1;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rdadj_busy", {31'b0, busy}, 32'd0);
        check("rdadj_done", {31'b0, done}, 32'd0);
        check("rdadj_res", {24'b0, res}, 32'd0);
        check("rdadj_flags", {28'b0, co, v, n, z}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        run(vt[3].op, vt[3].dec, vt[3].a, vt[3].b, vt[3].ci, vt[3].e, "after_rdadj");
        repeat (4) @(negedge clk);
        check("aborted_no_done", n_done - d0, 2);
        check("sb_empty", sbq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
